// File: rtl/cpu_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, CPU_BUSY, EXT_BUSY)
//   req_sel_t   : which requester won arbitration
//   STARVE_LIMIT_DEF / TIMEOUT_DEF : default parameter values
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        EXT_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        SEL_CPU = 1'b0,
        SEL_EXT = 1'b1
    } req_sel_t;

    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned TIMEOUT_DEF      = 255;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Loadable, clearable down-counter used as the access watchdog.
//   clk, rst     : clock, asynchronous active-high reset
//   i_clr        : force count to zero (highest priority)
//   i_load       : load i_load_val
//   i_load_val   : value loaded at grant (0 disables expiry)
//   i_dec        : decrement by one, saturating at zero
//   o_expire     : high during the last permitted cycle (count == 1)
module arb_timeout_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A loaded value of zero never reaches one, so a zero load disables expiry.
    assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU EX stage and one external requester.
//   clk, rst                        : clock, asynchronous active-high reset
//   cpu_req/wr/addr/wdata           : CPU access request, held until cpu_done
//   cpu_stall, cpu_done, cpu_rdata  : pipeline freeze, completion pulse, load data
//   ext_req/wr/addr/wdata           : external access request, held until ext_done
//   ext_gnt, ext_done, ext_rdata    : in-flight flag, completion pulse, read data
//   mem_req/wr/addr/wdata           : registered memory request, held until mem_ready
//   mem_rdata, mem_ready            : memory response
//   err                             : pulses with done when the access timed out
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ext_req,
    input  logic          ext_wr,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_done,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err
);

    localparam int unsigned   TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT);
    localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    req_sel_t      w_sel;
    logic          w_grant;
    logic          w_complete;
    logic          w_abort;
    logic          w_busy;
    logic          w_tmo_expire;

    logic          r_mem_req;
    logic          r_mem_wr;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_ext_rdata;
    logic          r_cpu_done;
    logic          r_ext_done;
    logic          r_err;
    logic [3:0]    r_starve_cnt;

    assign w_busy = (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_sel       = SEL_CPU;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Starvation guard overrides the normal CPU-first priority.
                if (ext_req && (r_starve_cnt == STARVE_MAX)) begin
                    w_grant = 1'b1;
                    w_sel   = SEL_EXT;
                end else if (cpu_req) begin
                    w_grant = 1'b1;
                    w_sel   = SEL_CPU;
                end else if (ext_req) begin
                    w_grant = 1'b1;
                    w_sel   = SEL_EXT;
                end
                if (w_grant) begin
                    w_state_nxt = (w_sel == SEL_EXT) ? EXT_BUSY : CPU_BUSY;
                end
            end
            CPU_BUSY, EXT_BUSY: begin
                // mem_ready takes precedence over a coinciding watchdog expiry.
                if (mem_ready) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_tmo_expire) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_ext_rdata <= '0;
            r_cpu_done  <= 1'b0;
            r_ext_done  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cpu_done <= 1'b0;
            r_ext_done <= 1'b0;
            r_err      <= 1'b0;
            if (w_grant) begin
                r_mem_req <= 1'b1;
                if (w_sel == SEL_EXT) begin
                    r_mem_wr    <= ext_wr;
                    r_mem_addr  <= ext_addr;
                    r_mem_wdata <= ext_wdata;
                end else begin
                    r_mem_wr    <= cpu_wr;
                    r_mem_addr  <= cpu_addr;
                    r_mem_wdata <= cpu_wdata;
                end
            end
            if (w_complete || w_abort) begin
                r_mem_req <= 1'b0;
                r_err     <= w_abort;
                if (r_state == CPU_BUSY) begin
                    r_cpu_done <= 1'b1;
                end else begin
                    r_ext_done <= 1'b1;
                end
                if (w_complete && !r_mem_wr) begin
                    if (r_state == CPU_BUSY) begin
                        r_cpu_rdata <= mem_rdata;
                    end else begin
                        r_ext_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    // Counts CPU wins taken while ext is waiting; any cycle without ext_req resets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant && (w_sel == SEL_CPU) && ext_req) begin
            if (r_starve_cnt < STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else if ((w_grant && (w_sel == SEL_EXT)) || !ext_req) begin
            r_starve_cnt <= '0;
        end
    end

    arb_timeout_cnt #(
        .W (TW)
    ) u_tmo (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_complete | w_abort),
        .i_load     (w_grant),
        .i_load_val (TMO_LOAD),
        .i_dec      (w_busy),
        .o_expire   (w_tmo_expire)
    );

    assign mem_req   = r_mem_req;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_done  = r_cpu_done;
    assign cpu_rdata = r_cpu_rdata;
    assign ext_done  = r_ext_done;
    assign ext_rdata = r_ext_rdata;
    assign err       = r_err;
    assign ext_gnt   = (r_state == EXT_BUSY);
    // Held low during reset so every output reads zero while rst is asserted.
    assign cpu_stall = cpu_req & ~r_cpu_done & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int STARVE = 4;
    localparam int TMO    = 8;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_done;
    logic [31:0] cpu_rdata;
    logic        ext_req, ext_wr;
    logic [31:0] ext_addr, ext_wdata;
    logic        ext_gnt, ext_done;
    logic [31:0] ext_rdata;
    logic        mem_req, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        err;

    int          n_checks;
    int          n_errors;
    int unsigned busy_n;
    int unsigned lat_target;
    logic        rd_fix;
    logic [31:0] rd_val;
    bit          rand_mode;

    // Reference model state: who owns the port and for how long.
    int          m_owner;   // 0 none, 1 cpu, 2 ext
    int          m_starve;
    int          m_elapsed;
    logic        m_mem_wr;
    logic [31:0] m_addr, m_wdata, m_cpu_rd, m_ext_rd;
    logic        m_cpu_done, m_ext_done, m_err;

    dmem_arbiter #(
        .AW           (32),
        .DW           (32),
        .STARVE_LIMIT (STARVE),
        .TIMEOUT      (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .ext_req   (ext_req),
        .ext_wr    (ext_wr),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_gnt   (ext_gnt),
        .ext_done  (ext_done),
        .ext_rdata (ext_rdata),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = 0; m_starve = 0; m_elapsed = 0; m_mem_wr = 1'b0;
            m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_ext_rd = '0;
            m_cpu_done = 1'b0; m_ext_done = 1'b0; m_err = 1'b0;
        end else begin
            m_cpu_done = 1'b0; m_ext_done = 1'b0; m_err = 1'b0;
            if (m_owner == 0) begin
                m_elapsed = 0;
                if (ext_req && m_starve == STARVE) begin
                    m_owner = 2; m_mem_wr = ext_wr; m_addr = ext_addr; m_wdata = ext_wdata;
                    m_starve = 0;
                end else if (cpu_req) begin
                    m_owner = 1; m_mem_wr = cpu_wr; m_addr = cpu_addr; m_wdata = cpu_wdata;
                    m_starve = ext_req ? ((m_starve < STARVE) ? m_starve + 1 : STARVE) : 0;
                end else if (ext_req) begin
                    m_owner = 2; m_mem_wr = ext_wr; m_addr = ext_addr; m_wdata = ext_wdata;
                    m_starve = 0;
                end else begin
                    m_starve = 0;
                end
            end else begin
                m_elapsed++;
                if (!ext_req) m_starve = 0;
                if (mem_ready || (TMO != 0 && m_elapsed >= TMO)) begin
                    m_err = !mem_ready;
                    if (m_owner == 1) m_cpu_done = 1'b1;
                    else              m_ext_done = 1'b1;
                    if (mem_ready && !m_mem_wr) begin
                        if (m_owner == 1) m_cpu_rd = mem_rdata;
                        else              m_ext_rd = mem_rdata;
                    end
                    m_owner = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("mem_req", 64'(mem_req), 64'(m_owner != 0));
        check("ext_gnt", 64'(ext_gnt), 64'(m_owner == 2));
        check("cpu_done", 64'(cpu_done), 64'(m_cpu_done));
        check("ext_done", 64'(ext_done), 64'(m_ext_done));
        check("err", 64'(err), 64'(m_err));
        check("cpu_rdata", 64'(cpu_rdata), 64'(m_cpu_rd));
        check("ext_rdata", 64'(ext_rdata), 64'(m_ext_rd));
        check("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !m_cpu_done && !rst));
        if (m_owner != 0 || rst) begin
            check("mem_wr", 64'(mem_wr), 64'(m_mem_wr));
            check("mem_addr", 64'(mem_addr), 64'(m_addr));
            check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
    endtask

    task automatic drive_mem();
        if (mem_req) begin
            busy_n++;
            mem_ready = (busy_n == lat_target);
        end else begin
            busy_n    = 0;
            mem_ready = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (rand_mode) begin
                // 0 never answers (timeout); 8 lands on the expiry cycle.
                if ($urandom_range(0, 5) == 0) lat_target = ($urandom_range(0, 1) == 0) ? 0 : 8;
                else                           lat_target = $urandom_range(1, 4);
            end
        end
        mem_rdata = rd_fix ? rd_val : $urandom;
    endtask

    task automatic new_cpu();
        cpu_req = 1'b1; cpu_wr = 1'($urandom_range(0, 1)); cpu_addr = $urandom; cpu_wdata = $urandom;
    endtask

    task automatic new_ext();
        ext_req = 1'b1; ext_wr = 1'($urandom_range(0, 1)); ext_addr = $urandom; ext_wdata = $urandom;
    endtask

    task automatic drive_reqs();
        if (cpu_req) begin
            if (cpu_done) begin
                if ($urandom_range(0, 2) == 0) new_cpu();
                else cpu_req = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
                cpu_req = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            new_cpu();
        end
        if (ext_req) begin
            if (ext_done) begin
                if ($urandom_range(0, 3) == 0) new_ext();
                else ext_req = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                ext_req = 1'b0;
            end
        end else if ($urandom_range(0, 4) == 0) begin
            new_ext();
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        drive_mem();
        if (rand_mode) drive_reqs();
    endtask

    initial begin
        int          n_busy;
        bit          got;
        logic [5:0]  order;
        int          ng;
        int          cpu_before;
        bit          ext_seen;
        logic [31:0] saved;

        n_checks = 0; n_errors = 0; busy_n = 0; lat_target = 1;
        rd_fix = 1'b0; rd_val = '0; rand_mode = 1'b0;
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 0; ext_wr = 0; ext_addr = '0; ext_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) cycle();
        check("reset_mem_req", 64'(mem_req), 64'd0);
        rst = 1'b0;
        cycle();

        // CPU load with three-cycle memory latency.
        rd_fix = 1'b1; rd_val = 32'hDEADBEEF; lat_target = 3;
        cpu_wr = 1'b0; cpu_addr = 32'h100; cpu_req = 1'b1;
        n_busy = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (mem_req) begin
                n_busy++;
                check("t1_addr", 64'(mem_addr), 64'h100);
                check("t1_wr", 64'(mem_wr), 64'd0);
            end
            if (cpu_done) begin
                got = 1;
                check("t1_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
                check("t1_stall", 64'(cpu_stall), 64'd0);
                cpu_req = 1'b0;
            end
        end
        check("t1_done_seen", 64'(got), 64'd1);
        check("t1_busy_cycles", 64'(n_busy), 64'd3);
        cycle();

        // Starvation guard: simultaneous requests, CPU held continuously.
        rd_fix = 1'b0; lat_target = 1;
        cpu_wr = 1'b0; cpu_addr = 32'h200; ext_wr = 1'b0; ext_addr = 32'h300;
        cpu_req = 1'b1; ext_req = 1'b1;
        order = '0; ng = 0; cpu_before = 0; ext_seen = 0;
        for (int i = 0; i < 60 && ng < 6; i++) begin
            cycle();
            if (mem_req && busy_n == 1) begin
                order = {order[4:0], ext_gnt};
                ng++;
            end
            if (cpu_done && !ext_seen) cpu_before++;
            if (ext_done) begin
                ext_seen = 1;
                ext_req  = 1'b0;
            end
        end
        cpu_req = 1'b0;
        check("t2_grants", 64'(ng), 64'd6);
        check("t2_order", 64'(order), 64'b000010);
        check("t2_cpu_before_ext", 64'(cpu_before), 64'd4);
        check("t2_ext_done_seen", 64'(ext_seen), 64'd1);
        repeat (4) cycle();

        // External write; CPU request raised mid-access must wait.
        lat_target = 4; saved = m_ext_rd;
        ext_wr = 1'b1; ext_addr = 32'h20; ext_wdata = 32'h55; ext_req = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (mem_req && busy_n == 1) begin
                check("t3_gnt", 64'(ext_gnt), 64'd1);
                check("t3_wr", 64'(mem_wr), 64'd1);
                check("t3_wdata", 64'(mem_wdata), 64'h55);
                check("t3_addr", 64'(mem_addr), 64'h20);
                cpu_wr = 1'b0; cpu_addr = 32'h104; cpu_req = 1'b1;
            end else if (ext_gnt) begin
                check("t3_cpu_stall", 64'(cpu_stall), 64'd1);
            end
            if (ext_done) begin
                got = 1;
                check("t3_ext_rdata_kept", 64'(ext_rdata), 64'(saved));
                ext_req = 1'b0;
            end
        end
        check("t3_done_seen", 64'(got), 64'd1);
        lat_target = 2; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (cpu_done) begin got = 1; cpu_req = 1'b0; end
        end
        check("t3_cpu_after", 64'(got), 64'd1);

        // Timeout: memory never answers.
        lat_target = 0; saved = m_cpu_rd;
        cpu_wr = 1'b0; cpu_addr = 32'h140; cpu_req = 1'b1;
        n_busy = 0; got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle();
            if (mem_req) n_busy++;
            if (cpu_done) begin
                got = 1;
                check("t4_err", 64'(err), 64'd1);
                check("t4_rdata_kept", 64'(cpu_rdata), 64'(saved));
                cpu_req = 1'b0;
            end
        end
        check("t4_done_seen", 64'(got), 64'd1);
        check("t4_busy_cycles", 64'(n_busy), 64'(TMO));
        cycle();
        check("t4_err_one_cycle", 64'(err), 64'd0);

        // mem_ready on the expiry cycle wins.
        rd_fix = 1'b1; rd_val = 32'hA5A50006; lat_target = 8;
        cpu_addr = 32'h144; cpu_req = 1'b1; got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle();
            if (cpu_done) begin
                got = 1;
                check("t6_err", 64'(err), 64'd0);
                check("t6_rdata", 64'(cpu_rdata), 64'hA5A50006);
                cpu_req = 1'b0;
            end
        end
        check("t6_done_seen", 64'(got), 64'd1);
        cycle();

        // Reset in the middle of an access.
        lat_target = 0; cpu_addr = 32'h180; cpu_req = 1'b1;
        repeat (3) cycle();
        check("t5_busy_before", 64'(mem_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_mem_req", 64'(mem_req), 64'd0);
        check("t5_stall", 64'(cpu_stall), 64'd0);
        check("t5_done", 64'(cpu_done), 64'd0);
        check("t5_err", 64'(err), 64'd0);
        repeat (2) cycle();
        rst = 1'b0;
        rd_val = 32'h0BADF00D; lat_target = 2; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (cpu_done) begin
                got = 1;
                check("t5_rdata", 64'(cpu_rdata), 64'h0BADF00D);
                cpu_req = 1'b0;
            end
        end
        check("t5_done_seen", 64'(got), 64'd1);
        cycle();

        // Randomized traffic against the model.
        rd_fix = 1'b0; rand_mode = 1'b1;
        repeat (3000) cycle();
        rand_mode = 1'b0; cpu_req = 1'b0; ext_req = 1'b0;
        repeat (20) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
